// File: rtl/column_select_debouncer.sv
// Column button front end: two-flop synchroniser, stability debouncer and a
// press/transfer/release FSM delivering one encoded column per physical press.
module column_select_debouncer #(
   parameter int NUM_COLS        = 4,
   parameter int COL_W           = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COLS-1:0] in_column,
   input  logic                col_ready,
   output logic [COL_W-1:0]    column_decode,
   output logic                col_valid,
   output logic                multi_err
);

   typedef enum logic [1:0] {IDLE, PRESENT, WAIT_RELEASE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [NUM_COLS-1:0] s1_q, s1_d, s2_q, s2_d, cand_q, cand_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   state_t              state_q, state_d;
   logic [COL_W-1:0]    column_decode_q, column_decode_d;
   logic                col_valid_q, col_valid_d;
   logic                multi_err_q, multi_err_d;
   logic                stable;

   function automatic int count_ones(input logic [NUM_COLS-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   function automatic logic [COL_W-1:0] encode_col(input logic [NUM_COLS-1:0] v);
      logic [COL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (v[i]) idx = COL_W'(i);
      end
      return idx;
   endfunction

   assign stable = (cnt_q == CNT_MAX);

   // Any change of the synchronised vector restarts the count; it saturates once stable.
   always_comb begin
      s1_d   = in_column;
      s2_d   = s1_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
         cnt_d  = CNT_W'(1);
      end else if (cnt_q < CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d         = state_q;
      column_decode_d = column_decode_q;
      col_valid_d     = col_valid_q;
      multi_err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (stable && (count_ones(cand_q) == 1)) begin
               column_decode_d = encode_col(cand_q);
               col_valid_d     = 1'b1;
               state_d         = PRESENT;
            end else if (stable && (count_ones(cand_q) >= 2)) begin
               multi_err_d = 1'b1;
               state_d     = WAIT_RELEASE;
            end
         end
         PRESENT: begin
            // The move is held until taken, even if the button is released first.
            if (col_valid_q && col_ready) begin
               col_valid_d = 1'b0;
               state_d     = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (stable && (cand_q == '0)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q            <= '0;
         s2_q            <= '0;
         cand_q          <= '0;
         cnt_q           <= '0;
         state_q         <= IDLE;
         column_decode_q <= '0;
         col_valid_q     <= 1'b0;
         multi_err_q     <= 1'b0;
      end else begin
         s1_q            <= s1_d;
         s2_q            <= s2_d;
         cand_q          <= cand_d;
         cnt_q           <= cnt_d;
         state_q         <= state_d;
         column_decode_q <= column_decode_d;
         col_valid_q     <= col_valid_d;
         multi_err_q     <= multi_err_d;
      end
   end

   assign column_decode = column_decode_q;
   assign col_valid     = col_valid_q;
   assign multi_err     = multi_err_q;

endmodule

// File: doc/column_select_debouncer.md
Name: column_select_debouncer

Overview:
- Parametrised successor to the combinational one-hot column decoder.
- Synchronises, debounces and validates the raw per-column player buttons, encodes the pressed column, and delivers it to the game controller over a valid/ready handshake.
- Generalised to any column count (4 for the demo board, 7 for a full Connect4 board).
- Adds multi-press error reporting and release detection, so one physical press yields exactly one move.

Parameters:
- NUM_COLS, 4: number of column buttons; must be at least 2.
- COL_W, 2: width of the encoded column index; must be at least ceil(log2(NUM_COLS)).
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles an input vector must hold before it is accepted; must be at least 1.
- CNT_W, 3: stability counter width; must hold the value DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_column  input  NUM_COLS  raw button vector; bit i = column i; asynchronous to clk.
- col_ready  input  1  game controller can accept a move.
- column_decode  output  COL_W  encoded column index; bit 0 of in_column maps to index 0.
- col_valid  output  1  column_decode holds an accepted move.
- multi_err  output  1  one-cycle pulse when a stable multi-button press is rejected.

Behaviour:
- Clocking and reset: one clock; synchronous, active-high reset.
- Reset values: column_decode=0, col_valid=0, multi_err=0, both synchroniser stages=0, cand=0, cnt=0, FSM=IDLE.
- Reset asserted mid-operation abandons any pending move. This includes col_valid high with no col_ready yet.
- Synchroniser: two flops, s1<=in_column, s2<=s1.
- Stability tracker, evaluated at each edge:
  - if s2!=cand: cand<=s2, cnt<=1;
  - else if cnt<DEBOUNCE_CYCLES: cnt<=cnt+1 (saturates).
  - stable = (cnt==DEBOUNCE_CYCLES).
- Glitches shorter than DEBOUNCE_CYCLES restart the count and are never accepted.
- FSM, registered outputs:
  - IDLE, stable and cand one-hot: column_decode<=index of set bit, col_valid<=1, go to PRESENT.
  - IDLE, stable and cand has 2 or more bits set: multi_err<=1 for exactly one cycle, go to WAIT_RELEASE, col_valid stays 0.
  - IDLE, stable and cand==0, or not stable: stay.
  - PRESENT: col_valid and column_decode are held unchanged regardless of in_column. On an edge with col_valid=1 and col_ready=1 (transfer), col_valid<=0 and go to WAIT_RELEASE.
  - WAIT_RELEASE: ignore all presses. When stable and cand==0, go to IDLE.
- Latency: a clean step on in_column sampled at edge k gives col_valid=1 after edge k+DEBOUNCE_CYCLES+2 (k+6 at default).
- If col_ready is held high, col_valid is a single-cycle pulse.
- col_ready while col_valid=0 has no effect.
- Releasing the button while in PRESENT does not withdraw the move. After transfer the FSM goes to WAIT_RELEASE and returns to IDLE once the all-zero vector is stable.
- A new column pressed before full release is ignored. A fresh move requires a stable all-zero vector, then a new stable one-hot vector.
- multi_err does not re-pulse while the same multi-press is held.
- column_decode retains its last value after transfer. It is only meaningful while col_valid=1.

Test Plan:
- Reset, then in_column=4'b0000 for 20 cycles -> col_valid=0, multi_err=0, column_decode=0 throughout.
- col_ready=1; in_column=4'b0100 applied before edge k and held -> column_decode=2 and col_valid=1 for exactly one cycle after edge k+6. Release, then 4'b1000 -> one further pulse with column_decode=3.
- col_ready=0; press 4'b0010, release after 10 cycles -> col_valid stays high with column_decode=1. Assert col_ready 5 cycles later -> col_valid drops on the next edge. No second pulse until a new press.
- Bounce: in_column toggles 4'b0001/4'b0000 every 2 cycles for 12 cycles, then holds 4'b0001 -> exactly one col_valid pulse with column_decode=0, after edge (last change)+6.
- in_column=4'b0110 held -> one multi_err pulse, col_valid never asserts. Change to 4'b0100 without release -> ignored. Release, then 4'b0100 -> column_decode=2 is accepted.
- NUM_COLS=7, COL_W=3 instance: press 7'b1000000 -> column_decode=6. Assert reset while col_valid=1 -> all outputs 0 on the next edge, and no move is delivered after reset is removed until a fresh press.
